line_clear_ctrl: RTL and testbench
==================================

Name: line_clear_ctrl

Overview:
- Sequences row removal on the placed-block board after a piece locks.
- The game FSM hands it a board snapshot. It scans the rows bottom-up and collapses every full row by shifting the rows above it down, one row per cycle. It then writes the board back and updates the 4-digit BCD score that drives the score display.
- Sits between the main game FSM and the placed-board register; it replaces ad-hoc row clearing in the play loop.

Parameters:
- W, 10, board width in blocks.
- H, 20, board height in blocks; row 0 is the top row; board bit index = y*W + x.
- YB, 5, width of row index and line counter (must satisfy 2^YB > H).

Ports:
- clk  in  1  game clock (25 MHz domain).
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request to process board_in; accepted only when ready=1.
- ready  out  1  high in IDLE only.
- board_in  in  W*H  board snapshot; sampled on the accept edge.
- board_out  out  W*H  processed board; valid while done=1.
- done  out  1  one-cycle pulse; board_out, lines_cleared and score are final.
- lines_cleared  out  YB  number of rows removed in this pass; valid with done.
- score_clr  in  1  zeroes the score (new game).
- score  out  16  BCD {thousands, hundreds, tens, ones}.

Behaviour:
- Reset values (rst_n=0 at a clk edge): state=IDLE, ready=1, done=0, board_out=0, lines_cleared=0, score=16'h0000. Reset mid-pass abandons the pass with no done pulse; the internal board copy is discarded.
- States: IDLE, SCAN, SHIFT, SCORE, DONE.
- IDLE
  - start=1: latch board_in into internal board_q; row_idx=H-1; k=0; go to SCAN.
  - start=0: stay in IDLE.
  - start is ignored in all other states (no queuing).
- SCAN (one row per cycle)
  - Row row_idx all ones: shift_row=row_idx; go to SHIFT.
  - Else if row_idx==0: go to SCORE.
  - Else: row_idx-1; stay in SCAN.
- SHIFT (one row per cycle)
  - shift_row>0: row[shift_row] <= row[shift_row-1]; shift_row-1.
  - shift_row==0: row 0 <= 0; k+1; return to SCAN at the same row_idx, because that row now holds new content and is rescanned.
- SCORE (1 cycle): score <= BCD(score + points(k)), saturating at 9999 with all digits at 9. k=0 leaves the score unchanged.
- DONE (1 cycle): done=1; board_out=board_q; lines_cleared=k; next state IDLE.
- board_out and lines_cleared hold their values until the next done.
- Latency, with the accept cycle as cycle 0:
  - done is high in cycle H + k + S + 2, where S = sum of (row_idx+1) over each cleared row.
  - No full rows, H=20: done at cycle 22.
  - Minimum start-to-start spacing: next start is accepted the cycle after done.
- score_clr
  - Effective in any state; takes priority over the SCORE update in the same cycle (score becomes 0).
  - Does not affect the pass in progress.
- A fully-filled board clears all H rows: k=H, no overflow, since YB is sized for H.

Optional Feature:
- Macro: LINE_BONUS_EN.
- Defined: points(k) = 0,1,3,5,8 for k = 0,1,2,3,4; k>4 gives 8.
- Undefined: points(k)=k.
- In both cases the addition is BCD and completes in the single SCORE cycle.

Test Plan:
- Empty board, start=1 for one cycle → ready drops next cycle; done at cycle 22; board_out=0; lines_cleared=0; score=0000.
- Row 19 full, row 18 bit x=3 set → done at cycle 43; board_out has only bit 19*W+3 set; lines_cleared=1; score=0001.
- Rows 19 and 17 full, score preloaded to 0998 via prior passes → lines_cleared=2; score=1000 without LINE_BONUS_EN, 1001 with it.
- Score at 9999, one full row → score stays 9999; lines_cleared=1.
- start held high during a pass, then rst_n=0 mid-SHIFT → no done pulse, board_out=0, score=0000, ready=1 the cycle after reset.
- score_clr asserted in the same cycle as SCORE with k=1 → score=0000; done still pulses with lines_cleared=1.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - row-clear sequencer with BCD score; LINE_BONUS_EN selects bonus scoring
module line_clear_ctrl #(
   parameter int W  = 10,
   parameter int H  = 20,
   parameter int YB = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic           ready,
   input  logic [W*H-1:0] board_in,
   output logic [W*H-1:0] board_out,
   output logic           done,
   output logic [YB-1:0]  lines_cleared,
   input  logic           score_clr,
   output logic [15:0]    score
);

   // Points are at least 4 bits wide so the bonus value 8 always fits.
   localparam int PW = (YB > 4) ? YB : 4;

   typedef enum logic [2:0] {IDLE, SCAN, SHIFT, SCORE, DONE} state_t;

   state_t         state_q, state_d;
   logic [W*H-1:0] board_q, board_d;
   logic [W*H-1:0] board_out_q;
   logic [YB-1:0]  row_idx_q, row_idx_d;
   logic [YB-1:0]  shift_row_q, shift_row_d;
   logic [YB-1:0]  k_q, k_d;
   logic [YB-1:0]  lines_q;
   logic [YB-1:0]  src_row;
   logic [15:0]    score_q;
   logic [15:0]    score_sum;
   logic           row_full;

   function automatic logic [PW-1:0] points(input logic [YB-1:0] k);
`ifdef LINE_BONUS_EN
      if (k == YB'(0))      return PW'(0);
      else if (k == YB'(1)) return PW'(1);
      else if (k == YB'(2)) return PW'(3);
      else if (k == YB'(3)) return PW'(5);
      else                  return PW'(8);
`else
      return PW'(k);
`endif
   endfunction

   // Digit-serial BCD add of a small binary value; carry out of the top digit pins 9999.
   function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [PW-1:0] p);
      logic [15:0] sum;
      logic [4:0]  dsum;
      logic [4:0]  carry;
      int          rem;
      sum   = '0;
      carry = '0;
      rem   = int'(p);
      for (int i = 0; i < 4; i++) begin
         dsum = {1'b0, a[4*i +: 4]} + {1'b0, 4'(rem % 10)} + carry;
         rem  = rem / 10;
         if (dsum > 5'd9) begin
            sum[4*i +: 4] = 4'(dsum - 5'd10);
            carry         = 5'd1;
         end else begin
            sum[4*i +: 4] = dsum[3:0];
            carry         = '0;
         end
      end
      return ((carry != '0) || (rem != 0)) ? 16'h9999 : sum;
   endfunction

   assign row_full  = &board_q[row_idx_q*W +: W];
   assign src_row   = shift_row_q - YB'(1);
   assign score_sum = bcd_add(score_q, points(k_q));

   assign board_out     = board_out_q;
   assign lines_cleared = lines_q;
   assign score         = score_q;

   // State register and working board copy; reset discards any pass in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         board_q     <= '0;
         row_idx_q   <= '0;
         shift_row_q <= '0;
         k_q         <= '0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         row_idx_q   <= row_idx_d;
         shift_row_q <= shift_row_d;
         k_q         <= k_d;
      end
   end

   // Results captured while in SCORE (board is final there) and held until the next pass
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         board_out_q <= '0;
         lines_q     <= '0;
      end else if (state_q == SCORE) begin
         board_out_q <= board_q;
         lines_q     <= k_q;
      end
   end

   // Score: clear wins over the SCORE-cycle update
   always_ff @(posedge clk) begin
      if (!rst_n || score_clr) begin
         score_q <= '0;
      end else if (state_q == SCORE) begin
         score_q <= score_sum;
      end
   end

   // Next-state logic: bottom-up scan, one-row-per-cycle collapse, rescan of the same row
   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      row_idx_d   = row_idx_q;
      shift_row_d = shift_row_q;
      k_d         = k_q;
      ready       = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               board_d   = board_in;
               row_idx_d = YB'(H - 1);
               k_d       = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (row_full) begin
               shift_row_d = row_idx_q;
               state_d     = SHIFT;
            end else if (row_idx_q == '0) begin
               state_d = SCORE;
            end else begin
               row_idx_d = row_idx_q - YB'(1);
            end
         end
         SHIFT: begin
            if (shift_row_q != '0) begin
               board_d[shift_row_q*W +: W] = board_q[src_row*W +: W];
               shift_row_d                 = src_row;
            end else begin
               board_d[W-1:0] = '0;
               k_d            = k_q + YB'(1);
               state_d        = SCAN;
            end
         end
         SCORE: state_d = DONE;
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - scoreboard bench for line_clear_ctrl
module tb_line_clear_ctrl;

   localparam int W   = 10;
   localparam int H   = 20;
   localparam int YB  = 5;
   localparam int WH  = W * H;
   localparam int SW  = 2;
   localparam int SH  = 2;
   localparam int SYB = 2;
   localparam int SWH = SW * SH;

   typedef struct {
      int            cyc;
      logic [WH-1:0] board;
      int            lines;
      logic [15:0]   score;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   int model   = 0;

   exp_t sb[$];
   exp_t ssb[$];

   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            ready;
   logic [WH-1:0]   board_in = '0;
   logic [WH-1:0]   board_out;
   logic            done;
   logic [YB-1:0]   lines_cleared;
   logic            score_clr = 1'b0;
   logic [15:0]     score;

   logic            s_rst_n = 1'b0;
   logic            s_start = 1'b0;
   logic            s_ready;
   logic [SWH-1:0]  s_board_in = '0;
   logic [SWH-1:0]  s_board_out;
   logic            s_done;
   logic [SYB-1:0]  s_lines;
   logic            s_score_clr = 1'b0;
   logic [15:0]     s_score;

   line_clear_ctrl #(.W(W), .H(H), .YB(YB)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
      .board_in(board_in), .board_out(board_out), .done(done),
      .lines_cleared(lines_cleared), .score_clr(score_clr), .score(score)
   );

   line_clear_ctrl #(.W(SW), .H(SH), .YB(SYB)) u_sat (
      .clk(clk), .rst_n(s_rst_n), .start(s_start), .ready(s_ready),
      .board_in(s_board_in), .board_out(s_board_out), .done(s_done),
      .lines_cleared(s_lines), .score_clr(s_score_clr), .score(s_score)
   );

   task automatic chk(input string nm, input logic [WH-1:0] act, input logic [WH-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for the DUT", nm);
   endtask

   function automatic int pts(input int k);
`ifdef LINE_BONUS_EN
      case (k)
         0: return 0;
         1: return 1;
         2: return 3;
         3: return 5;
         default: return 8;
      endcase
`else
      return k;
`endif
   endfunction

   function automatic int sat_add(input int s, input int k);
      int t;
      t = s + pts(k);
      return (t > 9999) ? 9999 : t;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int choose_k(input int r);
`ifdef LINE_BONUS_EN
      if (r >= 8)      return 4;
      else if (r >= 5) return 3;
      else if (r >= 3) return 2;
      else             return 1;
`else
      return (r < 5) ? r : 5;
`endif
   endfunction

   function automatic logic [WH-1:0] row_bits(input int y);
      logic [WH-1:0] m;
      m = '0;
      for (int x = 0; x < W; x++) m[y*W + x] = 1'b1;
      return m;
   endfunction

   // Main monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : mon_main
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("main_unexpected_done", WH'(done), WH'(0));
         end else begin
            e = sb.pop_front();
            chk("main_done_cycle", WH'(cyc), WH'(e.cyc));
            chk("main_board_out", board_out, e.board);
            chk("main_lines_cleared", WH'(lines_cleared), WH'(e.lines));
            chk("main_score", WH'(score), WH'(e.score));
         end
      end
   end

   // Saturation-instance monitor
   always @(negedge clk) begin : mon_sat
      exp_t e;
      if (s_done === 1'b1) begin
         if (ssb.size() == 0) begin
            chk("sat_unexpected_done", WH'(s_done), WH'(0));
         end else begin
            e = ssb.pop_front();
            chk("sat_done_cycle", WH'(cyc), WH'(e.cyc));
            chk("sat_board_out", WH'(s_board_out), e.board);
            chk("sat_lines_cleared", WH'(s_lines), WH'(e.lines));
            chk("sat_score", WH'(s_score), WH'(e.score));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) fail_timeout("main_ready");
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         fail_timeout("main_done");
         sb.delete();
      end
   endtask

   task automatic issue(input logic [WH-1:0] b, input int lat, input logic [WH-1:0] eb,
                        input int k, input int exp_score, output int acc);
      exp_t e;
      wait_ready();
      board_in = b;
      start    = 1'b1;
      acc      = cyc;
      e.cyc    = cyc + lat;
      e.board  = eb;
      e.lines  = k;
      e.score  = to_bcd(exp_score);
      sb.push_back(e);
      model    = exp_score;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic run_main();
      logic [WH-1:0] b;
      logic [WH-1:0] eb;
      int            acc;
      int            k;
      int            exp_sc;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", WH'(ready), WH'(1));
      chk("rst_done", WH'(done), WH'(0));
      chk("rst_board_out", board_out, '0);
      chk("rst_lines", WH'(lines_cleared), WH'(0));
      chk("rst_score", WH'(score), WH'(16'h0000));
      rst_n = 1'b1;

      // Empty board: H+2 latency, ready drops after accept
      issue('0, 22, '0, 0, 0, acc);
      chk("t1_ready_low", WH'(ready), WH'(0));
      wait_drain();

      // Row 19 full, one block above it falls into row 19
      b = row_bits(19);
      b[18*W + 3] = 1'b1;
      eb = '0;
      eb[19*W + 3] = 1'b1;
      issue(b, 43, eb, 1, 1, acc);
      wait_drain();

      // Preload score to 0998 with top-row clears
      score_clr = 1'b1;
      @(negedge clk);
      score_clr = 1'b0;
      chk("t3_score_clr", WH'(score), WH'(16'h0000));
      model = 0;
      for (int it = 0; it < 400 && model < 998; it++) begin
         k = choose_k(998 - model);
         b = '0;
         for (int y = 0; y < k; y++) b |= row_bits(y);
         issue(b, 22 + k + k*k, '0, k, model + pts(k), acc);
      end
      wait_drain();

      // Rows 19 and 17 full plus a block in row 16; BCD carry across three digits
      b = row_bits(19) | row_bits(17);
      b[16*W] = 1'b1;
      eb = '0;
      eb[18*W] = 1'b1;
`ifdef LINE_BONUS_EN
      exp_sc = 1001;
`else
      exp_sc = 1000;
`endif
      issue(b, 63, eb, 2, exp_sc, acc);
      wait_drain();

      // start held through a pass, reset mid-SHIFT: pass abandoned, no done
      wait_ready();
      board_in = row_bits(19);
      start    = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("t5_rst_ready", WH'(ready), WH'(1));
      chk("t5_rst_done", WH'(done), WH'(0));
      chk("t5_rst_board_out", board_out, '0);
      chk("t5_rst_lines", WH'(lines_cleared), WH'(0));
      chk("t5_rst_score", WH'(score), WH'(16'h0000));
      rst_n = 1'b1;
      model = 0;
      @(negedge clk);
      chk("t5_ready_after_rst", WH'(ready), WH'(1));
      repeat (30) @(negedge clk);

      // score_clr coincident with SCORE (cycle 42) beats the +points update
      issue(row_bits(19), 43, '0, 1, 0, acc);
      repeat (41) @(negedge clk);
      score_clr = 1'b1;
      @(negedge clk);
      score_clr = 1'b0;
      wait_drain();

      // Full board: every row cleared, lines_cleared = H
      issue('1, 442, '0, H, sat_add(model, H), acc);
      wait_drain();
   endtask

   // Small instance ramps its score to saturation with back-to-back full-board passes
   task automatic run_sat();
      exp_t e;
      int   smodel;
      int   extra;
      int   k;
      int   lat;
      int   n;
      smodel = 0;
      extra  = 0;
      s_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      s_rst_n = 1'b1;
      s_start = 1'b1;
      for (int it = 0; it < 6000 && extra < 4; it++) begin
         n = 0;
         while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (s_ready !== 1'b1) begin
            fail_timeout("sat_ready");
            break;
         end
         if (smodel == 9999) extra++;
         if (extra <= 2) begin
            s_board_in = 4'b1111;
            k   = 2;
            lat = 10;
         end else begin
            s_board_in = 4'b1100;
            k   = 1;
            lat = 7;
         end
         smodel  = sat_add(smodel, k);
         e.cyc   = cyc + lat;
         e.board = '0;
         e.lines = k;
         e.score = to_bcd(smodel);
         ssb.push_back(e);
         @(negedge clk);
      end
      s_start = 1'b0;
      n = 0;
      while (ssb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (ssb.size() != 0) begin
         fail_timeout("sat_done");
         ssb.delete();
      end
      chk("sat_final_score", WH'(s_score), WH'(16'h9999));
   endtask

   initial begin
      fork
         run_main();
         run_sat();
      join
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_tests++;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
